// File: rtl/y86_pkg.sv
// y86_pkg -- shared Y86-64 encodings for the decode/execute slice.
// Holds instruction codes, ALU and condition function codes, the one-hot
// status encoding, the "no register" specifier and the pipeline register
// layouts together with their bubble (reset) values.
package y86_pkg;

   localparam int WORD_W = 64;
   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [3:0] {
      I_HALT   = 4'h0, I_NOP    = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ    = 4'h6, I_JXX    = 4'h7,
      I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSHQ  = 4'hA, I_POPQ   = 4'hB
   } icode_e;

   typedef enum logic [3:0] {
      A_ADD = 4'h0, A_SUB = 4'h1, A_AND = 4'h2, A_XOR = 4'h3
   } alufn_e;

   typedef enum logic [3:0] {
      C_ALL = 4'h0, C_LE = 4'h1, C_L = 4'h2, C_E = 4'h3,
      C_NE  = 4'h4, C_GE = 4'h5, C_G = 4'h6
   } cond_e;

   typedef enum logic [2:0] {
      S_AOK = 3'b001, S_INS = 3'b010, S_HLT = 3'b100
   } stat_e;

   typedef struct packed {
      logic [2:0]        stat;
      logic [3:0]        icode;
      logic [3:0]        ifun;
      logic [3:0]        ra;
      logic [3:0]        rb;
      logic [WORD_W-1:0] valc;
      logic [WORD_W-1:0] valp;
   } d_reg_t;

   typedef struct packed {
      logic [2:0]        stat;
      logic [3:0]        icode;
      logic [3:0]        ifun;
      logic [WORD_W-1:0] valc;
      logic [WORD_W-1:0] vala;
      logic [WORD_W-1:0] valb;
   } e_reg_t;

   localparam d_reg_t D_BUBBLE = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0,
                                   ra: RNONE, rb: RNONE, valc: '0, valp: '0};
   localparam e_reg_t E_BUBBLE = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0,
                                   valc: '0, vala: '0, valb: '0};

endpackage

// File: rtl/y86_alu.sv
// y86_alu -- execute-stage ALU, branch/cmov condition and condition codes.
// Ports:
//   clk, rst_n          clock, async active-low reset (CC -> zf=1,sf=0,of=0)
//   stat_i/icode_i/ifun_i/valc_i/vala_i/valb_i   E-register contents
//   vale_o              combinational ALU result
//   cnd_o               condition result, evaluated on the CC value held
//                       before this instruction writes it
//   zf_o/sf_o/of_o      condition-code register
module y86_alu
   import y86_pkg::*;
#(
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2:0]    stat_i,
   input  logic [3:0]    icode_i,
   input  logic [3:0]    ifun_i,
   input  logic [DW-1:0] valc_i,
   input  logic [DW-1:0] vala_i,
   input  logic [DW-1:0] valb_i,
   output logic [DW-1:0] vale_o,
   output logic          cnd_o,
   output logic          zf_o,
   output logic          sf_o,
   output logic          of_o
);

   logic [DW-1:0] vale;
   logic          of_new, cc_we;
   logic          zf_q, sf_q, of_q;
   logic          zf_d, sf_d, of_d;

   always_comb begin
      vale   = '0;
      of_new = 1'b0;
      case (icode_i)
         I_OPQ: begin
            case (ifun_i)
               A_ADD: begin
                  vale   = valb_i + vala_i;
                  of_new = (vala_i[DW-1] == valb_i[DW-1]) && (vale[DW-1] != valb_i[DW-1]);
               end
               A_SUB: begin
                  vale   = valb_i - vala_i;
                  of_new = (vala_i[DW-1] != valb_i[DW-1]) && (vale[DW-1] != valb_i[DW-1]);
               end
               A_AND:   vale = valb_i & vala_i;
               A_XOR:   vale = valb_i ^ vala_i;
               default: vale = '0;
            endcase
         end
         I_RRMOVQ:          vale = vala_i;
         I_IRMOVQ:          vale = valc_i;
         I_RMMOVQ, I_MRMOVQ: vale = valb_i + valc_i;
         I_CALL, I_PUSHQ:   vale = valb_i - DW'(8);
         I_RET, I_POPQ:     vale = valb_i + DW'(8);
         default:           vale = '0;
      endcase
   end

   // Only well-formed OPq instructions with AOK status touch the flags.
   assign cc_we = (stat_i == S_AOK) && (icode_i == I_OPQ) && (ifun_i <= 4'd3);

   always_comb begin
      zf_d = zf_q;
      sf_d = sf_q;
      of_d = of_q;
      if (cc_we) begin
         zf_d = (vale == '0);
         sf_d = vale[DW-1];
         of_d = of_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zf_q <= 1'b1;
         sf_q <= 1'b0;
         of_q <= 1'b0;
      end else begin
         zf_q <= zf_d;
         sf_q <= sf_d;
         of_q <= of_d;
      end
   end

   // Uses the registered flags, so a cmov/jump sees the result of the
   // previous OPq, never its own instruction's update.
   always_comb begin
      cnd_o = 1'b0;
      if (icode_i == I_RRMOVQ || icode_i == I_JXX) begin
         case (ifun_i)
            C_ALL:   cnd_o = 1'b1;
            C_LE:    cnd_o = (sf_q ^ of_q) | zf_q;
            C_L:     cnd_o = sf_q ^ of_q;
            C_E:     cnd_o = zf_q;
            C_NE:    cnd_o = ~zf_q;
            C_GE:    cnd_o = ~(sf_q ^ of_q);
            C_G:     cnd_o = ~(sf_q ^ of_q) & ~zf_q;
            default: cnd_o = 1'b0;
         endcase
      end
   end

   assign vale_o = vale;
   assign zf_o   = zf_q;
   assign sf_o   = sf_q;
   assign of_o   = of_q;

endmodule

// File: rtl/decode_execute_pipe.sv
// decode_execute_pipe -- Y86-64 D and E pipeline registers plus execute ALU.
// Ports:
//   clk, rst_n                 clock, async active-low reset (both registers
//                              become bubbles, CC -> zf=1,sf=0,of=0)
//   f_stat..f_valP             fetched instruction, captured into D
//   d_valA, d_valB             register-file operands for the D-stage instr
//   d_stat..d_valP             D-register contents
//   e_stat..e_valB             E-register contents
//   e_valE, e_cnd              execute result and condition
//   zf, sf, of                 condition codes
// Optional build macro PIPE_CTRL_EN adds d_stall, d_bubble, e_bubble inputs;
// without it both registers load on every edge.
module decode_execute_pipe
   import y86_pkg::*;
#(
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst_n,
`ifdef PIPE_CTRL_EN
   input  logic          d_stall,
   input  logic          d_bubble,
   input  logic          e_bubble,
`endif
   input  logic [2:0]    f_stat,
   input  logic [3:0]    f_icode,
   input  logic [3:0]    f_ifun,
   input  logic [3:0]    f_rA,
   input  logic [3:0]    f_rB,
   input  logic [DW-1:0] f_valC,
   input  logic [DW-1:0] f_valP,
   input  logic [DW-1:0] d_valA,
   input  logic [DW-1:0] d_valB,
   output logic [2:0]    d_stat,
   output logic [3:0]    d_icode,
   output logic [3:0]    d_ifun,
   output logic [3:0]    d_rA,
   output logic [3:0]    d_rB,
   output logic [DW-1:0] d_valC,
   output logic [DW-1:0] d_valP,
   output logic [2:0]    e_stat,
   output logic [3:0]    e_icode,
   output logic [3:0]    e_ifun,
   output logic [DW-1:0] e_valC,
   output logic [DW-1:0] e_valA,
   output logic [DW-1:0] e_valB,
   output logic [DW-1:0] e_valE,
   output logic          e_cnd,
   output logic          zf,
   output logic          sf,
   output logic          of
);

   d_reg_t d_q, d_d, f_in;
   e_reg_t e_q, e_d, d_in;

   assign f_in = '{stat: f_stat, icode: f_icode, ifun: f_ifun, ra: f_rA,
                   rb: f_rB, valc: f_valC, valp: f_valP};
   assign d_in = '{stat: d_q.stat, icode: d_q.icode, ifun: d_q.ifun,
                   valc: d_q.valc, vala: d_valA, valb: d_valB};

   always_comb begin
      d_d = f_in;
      e_d = d_in;
`ifdef PIPE_CTRL_EN
      // Stall wins over bubble so a held instruction is never squashed.
      if (d_stall)       d_d = d_q;
      else if (d_bubble) d_d = D_BUBBLE;
      if (e_bubble)      e_d = E_BUBBLE;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q <= D_BUBBLE;
         e_q <= E_BUBBLE;
      end else begin
         d_q <= d_d;
         e_q <= e_d;
      end
   end

   assign d_stat  = d_q.stat;
   assign d_icode = d_q.icode;
   assign d_ifun  = d_q.ifun;
   assign d_rA    = d_q.ra;
   assign d_rB    = d_q.rb;
   assign d_valC  = d_q.valc;
   assign d_valP  = d_q.valp;

   assign e_stat  = e_q.stat;
   assign e_icode = e_q.icode;
   assign e_ifun  = e_q.ifun;
   assign e_valC  = e_q.valc;
   assign e_valA  = e_q.vala;
   assign e_valB  = e_q.valb;

   y86_alu #(.DW(DW)) u_alu (
      .clk    (clk),
      .rst_n  (rst_n),
      .stat_i (e_q.stat),
      .icode_i(e_q.icode),
      .ifun_i (e_q.ifun),
      .valc_i (e_q.valc),
      .vala_i (e_q.vala),
      .valb_i (e_q.valb),
      .vale_o (e_valE),
      .cnd_o  (e_cnd),
      .zf_o   (zf),
      .sf_o   (sf),
      .of_o   (of)
   );

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Scoreboard bench for decode_execute_pipe: each issued instruction pushes
// its hand-computed E-stage result; a negedge monitor pops and compares when
// that instruction reaches E. Expected flags are the CC value held while the
// instruction is in E, i.e. the result of the preceding OPq.
module tb_decode_execute_pipe;
   import y86_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  f_stat;
   logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
   logic [63:0] f_valC, f_valP, d_valA, d_valB;
   logic [2:0]  d_stat, e_stat;
   logic [3:0]  d_icode, d_ifun, d_rA, d_rB, e_icode, e_ifun;
   logic [63:0] d_valC, d_valP, e_valC, e_valA, e_valB, e_valE;
   logic        e_cnd, zf, sf, of;
`ifdef PIPE_CTRL_EN
   logic        d_stall = 1'b0, d_bubble = 1'b0, e_bubble = 1'b0;
`endif

   always #5 clk = ~clk;

   decode_execute_pipe #(.DW(64)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef PIPE_CTRL_EN
      .d_stall(d_stall), .d_bubble(d_bubble), .e_bubble(e_bubble),
`endif
      .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
      .f_valC(f_valC), .f_valP(f_valP), .d_valA(d_valA), .d_valB(d_valB),
      .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
      .d_valC(d_valC), .d_valP(d_valP),
      .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun), .e_valC(e_valC),
      .e_valA(e_valA), .e_valB(e_valB), .e_valE(e_valE), .e_cnd(e_cnd),
      .zf(zf), .sf(sf), .of(of)
   );

   typedef struct {
      logic [2:0]  stat;
      logic [3:0]  icode, ifun, ra, rb;
      logic [63:0] valc, valp, vala, valb, vale;
      logic        cnd, zf, sf, of;
   } vec_t;
   typedef struct {
      vec_t v;
      int   due;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0, failures = 0, cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // st, icode, ifun, valA, valB, valC, expected valE, cnd, flags before
   task automatic v(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                    input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                    input logic [63:0] ve, input logic cn, input logic z, input logic s,
                    input logic o);
      vec_t t;
      int   n;
      n = vecs.size();
      t = '{stat: st, icode: ic, ifun: fn, ra: 4'(n), rb: 4'(n + 3),
            valc: vc, valp: 64'h1000 + 64'(n * 10), vala: va, valb: vb,
            vale: ve, cnd: cn, zf: z, sf: s, of: o};
      vecs.push_back(t);
   endtask

   task automatic drive_nop();
      f_stat = 3'b001; f_icode = 4'h1; f_ifun = 4'h0; f_rA = 4'hF; f_rB = 4'hF;
      f_valC = '0; f_valP = '0;
   endtask

   // Monitor: compares the instruction scheduled to be in E this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            if (sb[0].due < cyc) begin
               e = sb.pop_front();
               checks++; failures++;
               $display("FAIL sb_missed: got none expected icode %h", e.v.icode);
            end else if (sb[0].due == cyc) begin
               e = sb.pop_front();
               chk("e_icode", 64'(e_icode), 64'(e.v.icode));
               chk("e_stat",  64'(e_stat),  64'(e.v.stat));
               chk("e_ifun",  64'(e_ifun),  64'(e.v.ifun));
               chk("e_valC",  e_valC, e.v.valc);
               chk("e_valA",  e_valA, e.v.vala);
               chk("e_valB",  e_valB, e.v.valb);
               chk("e_valE",  e_valE, e.v.vale);
               chk("e_cnd",   64'(e_cnd), 64'(e.v.cnd));
               chk("cc",      64'({zf, sf, of}), 64'({e.v.zf, e.v.sf, e.v.of}));
            end
         end
      end
   end

   initial begin
      logic [63:0] MAXP, MINN;
      MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
      MINN = 64'h8000_0000_0000_0000;
      rst_n = 1'b0;
      drive_nop();
      d_valA = '0; d_valB = '0;
      #12;
      chk("rst_d_icode", 64'(d_icode), 64'h1);
      chk("rst_e_icode", 64'(e_icode), 64'h1);
      chk("rst_d_stat",  64'(d_stat),  64'h1);
      chk("rst_d_rArB",  64'({d_rA, d_rB}), 64'hFF);
      chk("rst_cc",      64'({zf, sf, of}), 64'b100);
      @(negedge clk);
      rst_n = 1'b1;

      //     stat    ic    fn    valA   valB   valC     valE       cnd zf sf of
      v(3'b001, 4'h6, 4'h0, 64'd5, 64'd7, 64'h0,   64'd12,    0, 1, 0, 0); // add
      v(3'b001, 4'h6, 4'h1, 64'd9, 64'd9, 64'h0,   64'd0,     0, 0, 0, 0); // sub -> 0
      v(3'b001, 4'h7, 4'h3, 64'h0, 64'h0, 64'h40,  64'd0,     1, 1, 0, 0); // je
      v(3'b001, 4'h6, 4'h0, 64'd1, MAXP,  64'h0,   MINN,      0, 1, 0, 0); // add ovf
      v(3'b001, 4'h7, 4'h2, 64'h0, 64'h0, 64'h80,  64'd0,     0, 0, 1, 1); // jl
      v(3'b001, 4'h4, 4'h0, 64'h0, 64'h100, 64'h18, 64'h118,  0, 0, 1, 1); // rmmovq
      v(3'b001, 4'hA, 4'h0, 64'h0, 64'h200, 64'h0, 64'h1F8,   0, 0, 1, 1); // pushq
      v(3'b001, 4'hB, 4'h0, 64'h0, 64'h200, 64'h0, 64'h208,   0, 0, 1, 1); // popq
      v(3'b001, 4'h2, 4'h1, 64'h55, 64'h0, 64'h0,  64'h55,    0, 0, 1, 1); // cmovle
      v(3'b001, 4'h3, 4'h0, 64'h0, 64'h0, 64'hABC, 64'hABC,   0, 0, 1, 1); // irmovq
      v(3'b001, 4'h6, 4'h2, 64'hF0, 64'h3C, 64'h0, 64'h30,    0, 0, 1, 1); // and
      v(3'b001, 4'h6, 4'h3, 64'hFF, 64'hFF, 64'h0, 64'h0,     0, 0, 0, 0); // xor
      v(3'b001, 4'h7, 4'h5, 64'h0, 64'h0, 64'h0,   64'h0,     1, 1, 0, 0); // jge
      v(3'b001, 4'h7, 4'h6, 64'h0, 64'h0, 64'h0,   64'h0,     0, 1, 0, 0); // jg
      v(3'b001, 4'h6, 4'h1, 64'd1, 64'd0, 64'h0,   '1,        0, 1, 0, 0); // 0-1
      v(3'b001, 4'h7, 4'h4, 64'h0, 64'h0, 64'h0,   64'h0,     1, 0, 1, 0); // jne
      v(3'b001, 4'h6, 4'h4, 64'd1, 64'd2, 64'h0,   64'h0,     0, 0, 1, 0); // bad fn
      v(3'b001, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0,   64'h0,     0, 0, 1, 0); // nop
      v(3'b001, 4'h6, 4'h1, 64'd1, MINN,  64'h0,   MAXP,      0, 0, 1, 0); // sub ovf
      v(3'b001, 4'h2, 4'h0, 64'h77, 64'h0, 64'h0,  64'h77,    1, 0, 0, 1); // rrmovq
      v(3'b001, 4'h7, 4'h7, 64'h0, 64'h0, 64'h0,   64'h0,     0, 0, 0, 1); // fn>6
      v(3'b100, 4'h6, 4'h0, 64'h0, 64'h0, 64'h0,   64'h0,     0, 0, 0, 1); // HLT add
      v(3'b001, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0,   64'h0,     0, 0, 0, 1); // nop

      for (int k = 0; k <= vecs.size(); k++) begin
         @(posedge clk); #1;
         if (k > 0) begin
            chk("d_icode", 64'(d_icode), 64'(vecs[k-1].icode));
            chk("d_D",     {d_stat, d_ifun, d_rA, d_rB, 49'(d_valC)},
                           {vecs[k-1].stat, vecs[k-1].ifun, vecs[k-1].ra, vecs[k-1].rb,
                            49'(vecs[k-1].valc)});
            chk("d_valP",  d_valP, vecs[k-1].valp);
            d_valA = vecs[k-1].vala;
            d_valB = vecs[k-1].valb;
         end
         if (k < vecs.size()) begin
            f_stat = vecs[k].stat; f_icode = vecs[k].icode; f_ifun = vecs[k].ifun;
            f_rA = vecs[k].ra; f_rB = vecs[k].rb;
            f_valC = vecs[k].valc; f_valP = vecs[k].valp;
            sb.push_back('{vecs[k], cyc + 2});
         end else begin
            drive_nop();
         end
      end
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++; failures++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end

`ifdef PIPE_CTRL_EN
      @(posedge clk); #1;
      f_icode = 4'h3; f_valC = 64'h33; f_rA = 4'h2;
      @(posedge clk); #1;
      f_icode = 4'h6; f_valC = 64'h99; d_stall = 1'b1; d_bubble = 1'b1;
      @(posedge clk); #1;
      d_stall = 1'b0; d_bubble = 1'b0;
      chk("stall_icode", 64'(d_icode), 64'h3);
      chk("stall_valC",  d_valC, 64'h33);
      e_bubble = 1'b1; d_bubble = 1'b1;
      @(posedge clk); #1;
      e_bubble = 1'b0; d_bubble = 1'b0;
      chk("ebub_icode", 64'(e_icode), 64'h1);
      chk("ebub_stat",  64'(e_stat),  64'h1);
      chk("ebub_valE",  e_valE, 64'h0);
      chk("dbub_icode", 64'(d_icode), 64'h1);
      drive_nop();
`endif

      // Mid-run reset with non-bubble contents and non-reset flags.
      f_stat = 3'b100; f_icode = 4'h3; f_valC = 64'h5;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_d_icode", 64'(d_icode), 64'h1);
      chk("mrst_e_icode", 64'(e_icode), 64'h1);
      chk("mrst_stat",    64'({d_stat, e_stat}), 64'b001_001);
      chk("mrst_d_valC",  d_valC, 64'h0);
      chk("mrst_cc",      64'({zf, sf, of}), 64'b100);
      @(negedge clk);
      rst_n = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
